// File: rtl/ssb_sync_pkg.sv
// Shared types and helpers for the SSB acquisition/tracking controller.
package ssb_sync_pkg;

  localparam int N_ID_1_W = 9;
  localparam int N_ID_2_W = 2;
  localparam int N_ID_W   = 10;

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    WAIT_SSS = 2'd1,
    TRACK    = 2'd2
  } sync_state_e;

  // Physical cell ID = 3*N_id_1 + N_id_2, built from shift-and-add.
  function automatic logic [N_ID_W-1:0] compose_n_id(
    input logic [N_ID_1_W-1:0] n_id_1,
    input logic [N_ID_2_W-1:0] n_id_2
  );
    logic [N_ID_W-1:0] x1;
    x1 = {1'b0, n_id_1};
    return (x1 << 1) + x1 + {{(N_ID_W-N_ID_2_W){1'b0}}, n_id_2};
  endfunction

endpackage

// File: rtl/ssb_sync_ctrl_window_counter.sv
// Valid-sample counter with clear/load, plus tracking-window and close/timeout compares.
module ssb_window_counter #(
  parameter int SSB_PERIOD  = 76800,
  parameter int SEARCH_WIN  = 64,
  parameter int SSS_TIMEOUT = 4096,
  parameter int CNT_W       = $clog2(SSB_PERIOD + SEARCH_WIN + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             in_win_o,
  output logic             in_win_nxt_o,
  output logic             close_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] WIN_LO      = CNT_W'(SSB_PERIOD - SEARCH_WIN);
  localparam logic [CNT_W-1:0] WIN_HI      = CNT_W'(SSB_PERIOD + SEARCH_WIN);
  localparam logic [CNT_W-1:0] LOAD_VAL    = CNT_W'(SEARCH_WIN);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(SSS_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic in_window(input logic [CNT_W-1:0] c);
    return (c >= WIN_LO) && (c <= WIN_HI);
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && valid_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o        = cnt_q;
  assign in_win_o     = in_window(cnt_q);
  // Registered window output tracks the count it will sit next to.
  assign in_win_nxt_o = in_window(cnt_d);
  assign close_o      = (cnt_q >= WIN_HI);
  assign timeout_o    = (cnt_q >= TIMEOUT_VAL);

endmodule

// File: rtl/ssb_sync_ctrl.sv
// SSB acquisition/tracking sequencer between PSS detector, FFT demod and SSS detector.
// state    | meaning
// SEARCH   | waiting for any PSS peak, window fully open
// WAIT_SSS | FFT demod started, SSS detector armed, awaiting N_id_1
// TRACK    | flywheeling over the SSB period, in-window hits only
module ssb_sync_ctrl
  import ssb_sync_pkg::*;
#(
  parameter int SSB_PERIOD  = 76800,
  parameter int SEARCH_WIN  = 64,
  parameter int LOCK_CNT    = 2,
  parameter int MISS_MAX    = 3,
  parameter int SSS_TIMEOUT = 4096,
  parameter int CNT_W       = $clog2(SSB_PERIOD + SEARCH_WIN + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  s_axis_in_tvalid,
  input  logic                  peak_detected_i,
  input  logic [N_ID_2_W-1:0]   N_id_2_i,
  input  logic                  sss_valid_i,
  input  logic [N_ID_1_W-1:0]   N_id_1_i,
  output logic                  ssb_start_o,
  output logic [N_ID_2_W-1:0]   N_id_2_o,
  output logic                  N_id_2_valid_o,
  output logic                  pss_win_o,
  output logic                  locked_o,
  output logic [N_ID_W-1:0]     N_id_o,
  output logic                  N_id_valid_o,
  output logic signed [CNT_W:0] timing_err_o,
  output logic [1:0]            state_o
);

  localparam int HIT_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(MISS_MAX + 1);
  localparam int ERR_W  = CNT_W + 1;
  localparam logic [HIT_W-1:0]  LOCK_V   = HIT_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] MISS_V   = MISS_W'(MISS_MAX);
  localparam logic signed [ERR_W-1:0] PERIOD_S = ERR_W'(SSB_PERIOD);
  localparam int CNT_MAX = (SSS_TIMEOUT > SSB_PERIOD + SEARCH_WIN) ?
                           SSS_TIMEOUT : SSB_PERIOD + SEARCH_WIN;

  sync_state_e state_q, state_d;
  logic ssb_start_q, ssb_start_d;
  logic [N_ID_2_W-1:0] n_id_2_q, n_id_2_d;
  logic n_id_2_valid_q, n_id_2_valid_d;
  logic pss_win_q, pss_win_d;
  logic locked_q, locked_d;
  logic [N_ID_W-1:0] n_id_q, n_id_d;
  logic n_id_valid_q, n_id_valid_d;
  logic signed [ERR_W-1:0] timing_err_q, timing_err_d;
  logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [CNT_W-1:0] cnt;
  logic cnt_clr, cnt_load, cnt_en;
  logic cnt_in_win, cnt_in_win_nxt, cnt_close, cnt_timeout;
  logic hit, miss;

  assign cnt_en = (state_q != SEARCH);

  ssb_window_counter #(
    .SSB_PERIOD  (SSB_PERIOD),
    .SEARCH_WIN  (SEARCH_WIN),
    .SSS_TIMEOUT (SSS_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_win_cnt (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .valid_i      (s_axis_in_tvalid),
    .en_i         (cnt_en),
    .clr_i        (cnt_clr),
    .load_i       (cnt_load),
    .cnt_o        (cnt),
    .in_win_o     (cnt_in_win),
    .in_win_nxt_o (cnt_in_win_nxt),
    .close_o      (cnt_close),
    .timeout_o    (cnt_timeout)
  );

  always_comb begin
    state_d        = state_q;
    ssb_start_d    = 1'b0;
    n_id_2_valid_d = 1'b0;
    n_id_valid_d   = 1'b0;
    n_id_2_d       = n_id_2_q;
    n_id_d         = n_id_q;
    locked_d       = locked_q;
    timing_err_d   = timing_err_q;
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    cnt_clr        = 1'b0;
    cnt_load       = 1'b0;
    hit            = 1'b0;
    miss           = 1'b0;

    unique case (state_q)
      SEARCH: begin
        if (peak_detected_i) begin
          n_id_2_d       = N_id_2_i;
          hit_cnt_d      = HIT_W'(1);
          miss_cnt_d     = '0;
          ssb_start_d    = 1'b1;
          n_id_2_valid_d = 1'b1;
          cnt_clr        = 1'b1;
          state_d        = WAIT_SSS;
        end
      end

      WAIT_SSS: begin
        // A result arriving on the timeout sample still wins.
        if (sss_valid_i) begin
          n_id_d       = compose_n_id(N_id_1_i, n_id_2_q);
          n_id_valid_d = 1'b1;
          state_d      = TRACK;
        end else if (s_axis_in_tvalid && cnt_timeout) begin
          cnt_clr = 1'b1;
          state_d = SEARCH;
        end
      end

      TRACK: begin
        hit  = peak_detected_i && cnt_in_win && (N_id_2_i == n_id_2_q);
        miss = s_axis_in_tvalid && cnt_close && !hit;
        if (hit) begin
          timing_err_d = $signed({1'b0, cnt}) - PERIOD_S;
          ssb_start_d  = 1'b1;
          miss_cnt_d   = '0;
          hit_cnt_d    = (hit_cnt_q >= LOCK_V) ? LOCK_V : hit_cnt_q + 1'b1;
          if (hit_cnt_d == LOCK_V) begin
            locked_d = 1'b1;
          end
          cnt_clr = 1'b1;
        end else if (miss) begin
          miss_cnt_d = miss_cnt_q + 1'b1;
          hit_cnt_d  = '0;
          cnt_load   = 1'b1;
          if (miss_cnt_d >= MISS_V) begin
            locked_d = 1'b0;
            cnt_clr  = 1'b1;
            state_d  = SEARCH;
          end
        end
      end

      default: begin
        cnt_clr = 1'b1;
        state_d = SEARCH;
      end
    endcase
  end

  assign pss_win_d = (state_d == SEARCH) || ((state_d == TRACK) && cnt_in_win_nxt);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= SEARCH;
      ssb_start_q    <= 1'b0;
      n_id_2_q       <= '0;
      n_id_2_valid_q <= 1'b0;
      pss_win_q      <= 1'b1;
      locked_q       <= 1'b0;
      n_id_q         <= '0;
      n_id_valid_q   <= 1'b0;
      timing_err_q   <= '0;
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      ssb_start_q    <= ssb_start_d;
      n_id_2_q       <= n_id_2_d;
      n_id_2_valid_q <= n_id_2_valid_d;
      pss_win_q      <= pss_win_d;
      locked_q       <= locked_d;
      n_id_q         <= n_id_d;
      n_id_valid_q   <= n_id_valid_d;
      timing_err_q   <= timing_err_d;
      hit_cnt_q      <= hit_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
    end
  end

  assign ssb_start_o    = ssb_start_q;
  assign N_id_2_o       = n_id_2_q;
  assign N_id_2_valid_o = n_id_2_valid_q;
  assign pss_win_o      = pss_win_q;
  assign locked_o       = locked_q;
  assign N_id_o         = n_id_q;
  assign N_id_valid_o   = n_id_valid_q;
  assign timing_err_o   = timing_err_q;
  assign state_o        = state_q;

  // The counter never wraps: its largest legal value must fit CNT_W.
  cnt_bound_a: assert property (@(posedge clk_i) disable iff (reset_i)
    (32'(cnt) <= CNT_MAX) && (CNT_MAX < (1 << CNT_W)));

endmodule

// File: tb/tb_ssb_sync_ctrl.sv
// Self-checking bench for ssb_sync_ctrl: directed scenarios plus randomized run against a behavioural model.
module tb_ssb_sync_ctrl;

  localparam int P     = 1000;
  localparam int W     = 8;
  localparam int L     = 2;
  localparam int MM    = 2;
  localparam int TO    = 200;
  localparam int CNT_W = $clog2(P + W + 1);

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic valid = 1'b1;
  logic peak = 1'b0;
  logic sss = 1'b0;
  logic [1:0] nid2_in = '0;
  logic [8:0] nid1_in = '0;

  logic ssb_start_o, N_id_2_valid_o, pss_win_o, locked_o, N_id_valid_o;
  logic [1:0] N_id_2_o, state_o;
  logic [9:0] N_id_o;
  logic signed [CNT_W:0] timing_err_o;

  int total = 0;
  int bad = 0;

  // Behavioural reference: expected post-edge values.
  int m_state, m_cnt, m_hit, m_miss, m_nid2, m_nid, m_terr;
  bit m_locked, m_ssb, m_n2v, m_nv;

  ssb_sync_ctrl #(
    .SSB_PERIOD(P), .SEARCH_WIN(W), .LOCK_CNT(L), .MISS_MAX(MM), .SSS_TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .s_axis_in_tvalid(valid),
    .peak_detected_i(peak), .N_id_2_i(nid2_in), .sss_valid_i(sss), .N_id_1_i(nid1_in),
    .ssb_start_o(ssb_start_o), .N_id_2_o(N_id_2_o), .N_id_2_valid_o(N_id_2_valid_o),
    .pss_win_o(pss_win_o), .locked_o(locked_o), .N_id_o(N_id_o), .N_id_valid_o(N_id_valid_o),
    .timing_err_o(timing_err_o), .state_o(state_o)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit exp_win();
    return (m_state == 0) || (m_state == 2 && m_cnt >= P - W && m_cnt <= P + W);
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_hit = 0; m_miss = 0; m_nid2 = 0; m_nid = 0; m_terr = 0;
    m_locked = 0; m_ssb = 0; m_n2v = 0; m_nv = 0;
  endtask

  task automatic model_eval(input bit pk, input int n2, input bit ss, input int n1, input bit vl);
    m_ssb = 0; m_n2v = 0; m_nv = 0;
    if (m_state == 0) begin
      if (pk) begin
        m_nid2 = n2; m_cnt = 0; m_hit = 1; m_miss = 0; m_ssb = 1; m_n2v = 1; m_state = 1;
      end
    end else if (m_state == 1) begin
      if (ss) begin
        m_nid = 3 * n1 + m_nid2; m_nv = 1; m_state = 2;
        if (vl) m_cnt++;
      end else if (vl && m_cnt == TO) begin
        m_state = 0; m_cnt = 0;
      end else if (vl) m_cnt++;
    end else begin
      if (pk && n2 == m_nid2 && m_cnt >= P - W && m_cnt <= P + W) begin
        m_terr = m_cnt - P; m_cnt = 0; m_ssb = 1; m_miss = 0;
        m_hit = (m_hit + 1 > L) ? L : m_hit + 1;
        if (m_hit == L) m_locked = 1;
      end else if (vl && m_cnt == P + W) begin
        m_cnt = W; m_miss++; m_hit = 0;
        if (m_miss == MM) begin
          m_state = 0; m_locked = 0; m_cnt = 0;
        end
      end else if (vl) m_cnt++;
    end
  endtask

  task automatic step(input bit pk, input int n2, input bit ss, input int n1, input bit vl);
    peak = pk; nid2_in = 2'(n2); sss = ss; nid1_in = 9'(n1); valid = vl;
    model_eval(pk, n2, ss, n1, vl);
    @(posedge clk_i); #1;
    peak = 1'b0; sss = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
  endtask

  task automatic run_to_cnt(input int target);
    int guard;
    guard = 0;
    while (m_cnt != target && guard < 3000) begin
      step(0, 0, 0, 0, 1);
      guard++;
    end
    if (m_cnt != target) begin
      bad++;
      $display("FAIL run_to_cnt: reached=%0d target=%0d", m_cnt, target);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    total++; if (pss_win_o !== 1'b1) begin bad++; $display("FAIL reset_win got=%b exp=1", pss_win_o); end
    total++; if ({ssb_start_o, N_id_2_valid_o, N_id_valid_o, locked_o} !== 4'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {ssb_start_o, N_id_2_valid_o, N_id_valid_o, locked_o});
    end
    total++; if ({N_id_o, N_id_2_o, timing_err_o} !== '0) begin
      bad++; $display("FAIL reset_values got nid=%0d nid2=%0d terr=%0d exp 0", N_id_o, N_id_2_o, timing_err_o);
    end
  endtask

  task automatic test_acquire();
    step(1, 1, 0, 0, 1);
    total++; if ({ssb_start_o, N_id_2_valid_o} !== 2'b11) begin
      bad++; $display("FAIL acq_pulses got=%b exp=11", {ssb_start_o, N_id_2_valid_o});
    end
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL acq_state1 got=%0d exp=1", state_o); end
    total++; if (N_id_2_o !== 2'd1) begin bad++; $display("FAIL acq_nid2 got=%0d exp=1", N_id_2_o); end
    total++; if (pss_win_o !== 1'b0) begin bad++; $display("FAIL acq_win got=%b exp=0", pss_win_o); end
    step(1, 2, 0, 0, 1);
    total++; if ({ssb_start_o, N_id_2_valid_o} !== 2'b00) begin
      bad++; $display("FAIL acq_pulse_width got=%b exp=00", {ssb_start_o, N_id_2_valid_o});
    end
    idle(48);
    step(0, 0, 1, 100, 1);
    total++; if (N_id_o !== 10'd301) begin bad++; $display("FAIL acq_nid got=%0d exp=301", N_id_o); end
    total++; if (N_id_valid_o !== 1'b1) begin bad++; $display("FAIL acq_nid_valid got=%b exp=1", N_id_valid_o); end
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL acq_state2 got=%0d exp=2", state_o); end
    idle(1);
    total++; if (N_id_valid_o !== 1'b0) begin bad++; $display("FAIL acq_nid_valid_width got=%b exp=0", N_id_valid_o); end
  endtask

  task automatic test_lock();
    run_to_cnt(1003);
    total++; if (pss_win_o !== 1'b1) begin bad++; $display("FAIL lock_win_open got=%b exp=1", pss_win_o); end
    step(1, 1, 0, 0, 1);
    total++; if (ssb_start_o !== 1'b1) begin bad++; $display("FAIL lock_ssb got=%b exp=1", ssb_start_o); end
    total++; if (int'(timing_err_o) !== 3) begin bad++; $display("FAIL lock_terr got=%0d exp=3", timing_err_o); end
    total++; if (locked_o !== 1'b1) begin bad++; $display("FAIL lock_flag got=%b exp=1", locked_o); end
    total++; if (pss_win_o !== 1'b0) begin bad++; $display("FAIL lock_cnt_clear got=%b exp=0", pss_win_o); end
    run_to_cnt(995);
    step(1, 1, 0, 0, 1);
    total++; if (int'(timing_err_o) !== -5) begin bad++; $display("FAIL lock_terr_neg got=%0d exp=-5", timing_err_o); end
    total++; if ({ssb_start_o, locked_o} !== 2'b11) begin
      bad++; $display("FAIL lock_second got=%b exp=11", {ssb_start_o, locked_o});
    end
  endtask

  task automatic test_reject();
    run_to_cnt(900);
    step(1, 1, 0, 0, 1);
    total++; if (ssb_start_o !== 1'b0) begin bad++; $display("FAIL rej_early got=%b exp=0", ssb_start_o); end
    run_to_cnt(1000);
    step(1, 2, 0, 0, 1);
    total++; if (ssb_start_o !== 1'b0) begin bad++; $display("FAIL rej_nid2 got=%b exp=0", ssb_start_o); end
    total++; if (pss_win_o !== 1'b1) begin bad++; $display("FAIL rej_cnt_kept got=%b exp=1", pss_win_o); end
    total++; if (int'(timing_err_o) !== -5) begin bad++; $display("FAIL rej_terr got=%0d exp=-5", timing_err_o); end
  endtask

  task automatic test_loss();
    run_to_cnt(1008);
    step(0, 0, 0, 0, 1);
    total++; if ({state_o, locked_o, pss_win_o, ssb_start_o} !== {2'd2, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL loss_miss1 got state=%0d lock=%b win=%b ssb=%b exp 2 1 0 0",
                      state_o, locked_o, pss_win_o, ssb_start_o);
    end
    run_to_cnt(991);
    total++; if (pss_win_o !== 1'b0) begin bad++; $display("FAIL loss_fly_pre got=%b exp=0", pss_win_o); end
    step(0, 0, 0, 0, 1);
    total++; if (pss_win_o !== 1'b1) begin bad++; $display("FAIL loss_fly_open got=%b exp=1", pss_win_o); end
    run_to_cnt(1008);
    step(0, 0, 0, 0, 1);
    total++; if ({state_o, locked_o, pss_win_o} !== {2'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL loss_search got state=%0d lock=%b win=%b exp 0 0 1", state_o, locked_o, pss_win_o);
    end
  endtask

  task automatic test_timeout();
    int n, pulses;
    step(1, 3, 0, 0, 1);
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL to_enter got=%0d exp=1", state_o); end
    n = 0; pulses = 0;
    while (m_state == 1 && n < 400) begin
      step(0, 0, 0, 0, 1);
      n++;
      if (N_id_valid_o) pulses++;
      total++; if (state_o !== 2'(m_state)) begin
        bad++; $display("FAIL to_state cycle=%0d got=%0d exp=%0d", n, state_o, m_state);
      end
    end
    total++; if (n !== TO + 1) begin bad++; $display("FAIL to_latency got=%0d exp=%0d", n, TO + 1); end
    total++; if (pulses !== 0) begin bad++; $display("FAIL to_nid_valid got=%0d exp=0", pulses); end
    total++; if (pss_win_o !== 1'b1) begin bad++; $display("FAIL to_win got=%b exp=1", pss_win_o); end
  endtask

  task automatic test_boundary();
    step(1, 2, 0, 0, 1);
    idle(10);
    step(0, 0, 1, 5, 1);
    total++; if (N_id_o !== 10'd17) begin bad++; $display("FAIL bnd_nid got=%0d exp=17", N_id_o); end
    run_to_cnt(1008);
    step(1, 2, 0, 0, 1);
    total++; if ({ssb_start_o, locked_o, state_o} !== {1'b1, 1'b1, 2'd2}) begin
      bad++; $display("FAIL bnd_close_hit got ssb=%b lock=%b state=%0d exp 1 1 2", ssb_start_o, locked_o, state_o);
    end
    total++; if (int'(timing_err_o) !== 8) begin bad++; $display("FAIL bnd_terr got=%0d exp=8", timing_err_o); end
    idle(300);
    reset_i = 1'b1;
    #1;
    total++; if ({state_o, locked_o, pss_win_o, ssb_start_o} !== {2'd0, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL bnd_reset got state=%0d lock=%b win=%b ssb=%b exp 0 0 1 0",
                      state_o, locked_o, pss_win_o, ssb_start_o);
    end
    total++; if ({N_id_o, N_id_2_o, timing_err_o} !== '0) begin
      bad++; $display("FAIL bnd_reset_vals got nid=%0d nid2=%0d terr=%0d exp 0", N_id_o, N_id_2_o, timing_err_o);
    end
    model_reset();
    @(posedge clk_i); #1;
    reset_i = 1'b0;
  endtask

  task automatic test_random();
    logic [29:0] obs, exp;
    for (int i = 0; i < 20000; i++) begin
      bit pk, ss, vl;
      int n2, n1;
      vl = ($urandom_range(0, 7) != 0);
      if (m_state == 2 && m_cnt >= P - W - 2 && m_cnt <= P + W + 1) pk = ($urandom_range(0, 5) == 0);
      else pk = ($urandom_range(0, 299) == 0);
      n2 = (m_state == 2 && $urandom_range(0, 3) != 0) ? m_nid2 : int'($urandom_range(0, 3));
      ss = (m_state == 1) ? ($urandom_range(0, 179) == 0) : ($urandom_range(0, 99) == 0);
      n1 = $urandom_range(0, 335);
      step(pk, n2, ss, n1, vl);
      obs = {state_o, ssb_start_o, N_id_2_valid_o, pss_win_o, locked_o, N_id_2_o, N_id_o,
             N_id_valid_o, timing_err_o};
      exp = {2'(m_state), m_ssb, m_n2v, exp_win(), m_locked, 2'(m_nid2), 10'(m_nid),
             m_nv, 11'(m_terr)};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL random cycle=%0d got=%h exp=%h", i, obs, exp);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_acquire();
    test_lock();
    test_reject();
    test_loss();
    test_timeout();
    test_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
